// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target: START/STOP detect, 7-bit address match, ACK,
// byte receive to host and host-supplied byte transmit on an open-drain SDA.
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rd_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX_DATA,
    S_RX_ACK,
    S_TX_DATA,
    S_TX_ACK
  } state_t;

  logic       scl_meta_q, scl_sync_q, scl_prev_q;
  logic       sda_meta_q, sda_sync_q, sda_prev_q;
  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic       rw_q;
  logic       phase_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rd_req_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  // Sync flops idle high so leaving reset never fakes an edge on an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign byte_in   = {shift_q[6:0], sda_sync_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd7;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      if (start_det) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= 3'd7;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        phase_q   <= 1'b0;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        phase_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
          end
          S_ADDR: begin
            if (scl_rise) begin
              shift_q <= byte_in;
              if (bit_cnt_q != 3'd0) begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
              end else if (byte_in[7:1] == TARGET_ADDR) begin
                busy_q  <= 1'b1;
                rw_q    <= byte_in[0];
                phase_q <= 1'b0;
                state_q <= S_ADDR_ACK;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          // phase_q marks that the ACK low is already on the bus for this 9th bit.
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else if (rw_q) begin
                phase_q   <= 1'b0;
                shift_q   <= tx_data;
                rd_req_q  <= 1'b1;
                sda_oe_q  <= ~tx_data[7];
                bit_cnt_q <= 3'd7;
                state_q   <= S_TX_DATA;
              end else begin
                phase_q   <= 1'b0;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 3'd7;
                state_q   <= S_RX_DATA;
              end
            end
          end
          S_RX_DATA: begin
            if (scl_rise) begin
              shift_q <= byte_in;
              if (bit_cnt_q != 3'd0) begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
              end else begin
                rx_data_q  <= byte_in;
                rx_valid_q <= 1'b1;
                phase_q    <= 1'b0;
                state_q    <= S_RX_ACK;
              end
            end
          end
          S_RX_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                phase_q   <= 1'b0;
                bit_cnt_q <= 3'd7;
                state_q   <= S_RX_DATA;
              end
            end
          end
          S_TX_DATA: begin
            if (scl_fall) begin
              if (bit_cnt_q != 3'd0) begin
                sda_oe_q  <= ~shift_q[6];
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q - 3'd1;
              end else begin
                sda_oe_q <= 1'b0;
                phase_q  <= 1'b0;
                state_q  <= S_TX_ACK;
              end
            end
          end
          // phase_q here records a master ACK seen on the 9th rise, consumed on the next fall.
          S_TX_ACK: begin
            if (scl_rise) begin
              if (sda_sync_q) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                phase_q <= 1'b1;
              end
            end else if (scl_fall && phase_q) begin
              phase_q   <= 1'b0;
              shift_q   <= tx_data;
              rd_req_q  <= 1'b1;
              sda_oe_q  <= ~tx_data[7];
              bit_cnt_q <= 3'd7;
              state_q   <= S_TX_DATA;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// tb/tb_i2c_target_responder.sv - directed bus-master bench for i2c_target_responder.
`timescale 1ns/1ps
module tb_i2c_target_responder;

  localparam int Q = 80;

  logic       clk;
  logic       rst;
  logic       m_scl;
  logic       m_low;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_req;
  logic       busy;
  wire        sda_bus;

  int errors = 0;
  int checks = 0;
  int rxv_cnt = 0;
  int rdq_cnt = 0;
  int overlap_cnt = 0;
  int rogue_cnt = 0;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  i2c_target_responder #(.TARGET_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (m_scl),
    .sda      (sda_bus),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_req   (rd_req),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (rd_req) rdq_cnt <= rdq_cnt + 1;
    if (rx_valid && rd_req) overlap_cnt <= overlap_cnt + 1;
    if (sda_bus == 1'b0 && !m_low) rogue_cnt <= rogue_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_cycle(output logic sampled);
    #Q; m_scl = 1'b1;
    #Q; sampled = sda_bus;
    #Q; m_scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    if (!m_scl) begin
      m_low = 1'b0; #Q;
      m_scl = 1'b1; #Q;
    end
    m_low = 1'b1; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i];
      bit_cycle(s);
    end
    m_low = 1'b0;
    bit_cycle(s);
    ack = s;
  endtask

  task automatic read_byte(input logic [7:0] next_tx, input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0;
      bit_cycle(s);
      d[i] = s;
    end
    tx_data = next_tx;
    m_low = ~nack;
    bit_cycle(s);
    if (nack) m_low = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    int         rxv0, rdq0, rog0;

    m_scl = 1'b1; m_low = 1'b0; tx_data = 8'h00; rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", sda_bus, 1'b1);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write 0x50,W then 0xA5
    rxv0 = rxv_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", ack, 1'b0);
    check("wr_busy_set", busy, 1'b1);
    write_byte(8'hA5, ack);
    check("wr_data_ack", ack, 1'b0);
    check("wr_rx_data", rx_data, 8'hA5);
    check("wr_rxv_pulses", rxv_cnt - rxv0, 1);
    i2c_stop();
    check("wr_busy_clr", busy, 1'b0);

    // Address 0x51,W must be ignored
    rxv0 = rxv_cnt; rog0 = rogue_cnt;
    i2c_start();
    write_byte(8'hA2, ack);
    check("mis_nack", ack, 1'b1);
    check("mis_busy", busy, 1'b0);
    write_byte(8'h00, ack);
    i2c_stop();
    check("mis_no_drive", rogue_cnt - rog0, 0);
    check("mis_no_rxv", rxv_cnt - rxv0, 0);

    // Read 0x50,R with 0x3C, master ACK then STOP
    rxv0 = rxv_cnt; rdq0 = rdq_cnt;
    tx_data = 8'h3C;
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 1'b0);
    check("rd_req_first", rdq_cnt - rdq0, 1);
    read_byte(8'hFF, 1'b0, d);
    check("rd_byte_3c", d, 8'h3C);
    check("rd_req_second", rdq_cnt - rdq0, 2);
    i2c_stop();
    check("rd_busy_clr", busy, 1'b0);
    check("rd_sda_free", sda_bus, 1'b1);
    check("rd_no_rxv", rxv_cnt - rxv0, 0);

    // Two-byte read, NACK on the second
    rdq0 = rdq_cnt;
    tx_data = 8'h81;
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd2_addr_ack", ack, 1'b0);
    read_byte(8'h7E, 1'b0, d);
    check("rd2_byte0", d, 8'h81);
    read_byte(8'h00, 1'b1, d);
    check("rd2_byte1", d, 8'h7E);
    check("rd2_busy_nack", busy, 1'b0);
    check("rd2_sda_free", sda_bus, 1'b1);
    check("rd2_req_cnt", rdq_cnt - rdq0, 2);
    i2c_stop();

    // Reset after the 4th data bit of a write
    rxv0 = rxv_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    for (int i = 0; i < 4; i++) begin
      m_low = 1'b0;
      bit_cycle(s);
    end
    check("rst_mid_busy_pre", busy, 1'b1);
    @(negedge clk); #2; rst = 1'b1; #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_sda", sda_bus, 1'b1);
    check("rst_mid_rxv", rx_valid, 1'b0);
    check("rst_mid_rx_data", rx_data, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    i2c_start();
    write_byte(8'hA0, ack);
    check("post_rst_ack", ack, 1'b0);
    write_byte(8'h11, ack);
    check("post_rst_rx", rx_data, 8'h11);
    check("post_rst_rxv", rxv_cnt - rxv0, 1);
    i2c_stop();

    // Write 0x22, repeated START, then read
    rxv0 = rxv_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h22, ack);
    check("rs_wr_ack", ack, 1'b0);
    tx_data = 8'h5A;
    rdq0 = rdq_cnt;
    i2c_start();
    write_byte(8'hA1, ack);
    check("rs_rd_ack", ack, 1'b0);
    check("rs_rx_data", rx_data, 8'h22);
    check("rs_rxv_cnt", rxv_cnt - rxv0, 1);
    check("rs_rd_req", rdq_cnt - rdq0, 1);
    check("rs_busy", busy, 1'b1);
    read_byte(8'h00, 1'b1, d);
    check("rs_byte", d, 8'h5A);
    i2c_stop();
    check("rs_busy_clr", busy, 1'b0);

    check("no_overlap", overlap_cnt, 0);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
